// File: rtl/memory_writer_pkg.sv
// Shared types and helpers for the memory write-back path (state encoding, byte-lane helpers).
package mem_writer_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } state_e;

  function automatic logic [BYTES_PER_WORD-1:0] byte_lane(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Expands a per-byte mask into a per-bit mask across the whole word.
  function automatic logic [WORD_W-1:0] lane_bits(input logic [BYTES_PER_WORD-1:0] mask);
    logic [WORD_W-1:0] bits;
    bits = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      bits[8*i +: 8] = {8{mask[i]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/memory_writer_if.sv
// Result-byte stream plus memory write port of memory_writer.
// With MEM_WR_BYTE_MASK_EN defined the port also carries the mem_byte_en byte mask.
interface memory_writer_if #(
  parameter int ADR_W  = 8,
  parameter int DATA_W = 32
);
  logic              res_valid;
  logic [7:0]        res_data;
  logic              res_ready;
  logic              mem_wr_en;
  logic [ADR_W-1:0]  mem_wr_adr;
  logic [DATA_W-1:0] mem_wr_data;

`ifdef MEM_WR_BYTE_MASK_EN
  logic [3:0]        mem_byte_en;

  modport master (
    input  res_valid, res_data,
    output res_ready, mem_wr_en, mem_wr_adr, mem_wr_data, mem_byte_en
  );
  modport slave (
    output res_valid, res_data,
    input  res_ready, mem_wr_en, mem_wr_adr, mem_wr_data, mem_byte_en
  );
`else
  modport master (
    input  res_valid, res_data,
    output res_ready, mem_wr_en, mem_wr_adr, mem_wr_data
  );
  modport slave (
    output res_valid, res_data,
    input  res_ready, mem_wr_en, mem_wr_adr, mem_wr_data
  );
`endif

endinterface

// File: rtl/memory_writer_byte_packer.sv
// Packs result bytes little-endian into a 32-bit word; word/fill_mask already include a byte
// being loaded this cycle so the owner can capture the finished word on the same edge.
module byte_packer
  import mem_writer_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      load,
  input  logic [7:0]                data,
  output logic [WORD_W-1:0]         word,
  output logic                      full,
  output logic [BYTES_PER_WORD-1:0] fill_mask
);

  logic [WORD_W-1:0]         pack_q;
  logic [BYTES_PER_WORD-1:0] mask_q;
  logic [1:0]                byte_idx;

  always_comb begin
    word      = pack_q;
    fill_mask = mask_q;
    if (load) begin
      word[{byte_idx, 3'b000} +: 8] = data;
      fill_mask                     = mask_q | byte_lane(byte_idx);
    end
  end

  assign full = load && (byte_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pack_q   <= '0;
      mask_q   <= '0;
      byte_idx <= '0;
    end else if (load) begin
      pack_q   <= word;
      mask_q   <= fill_mask;
      byte_idx <= byte_idx + 2'd1;
    end
  end

endmodule

// File: rtl/memory_writer.sv
// Write-back end of the memory interface: packs result bytes four per word and writes them
// to base_adr + word index. MEM_WR_BYTE_MASK_EN enables the mem_byte_en byte mask.
//
// state   | meaning
// IDLE    | waiting for start; base_adr latched when start is seen
// COLLECT | res_ready high, accepting bytes into the packer
// WRITE   | one-cycle mem_wr_en strobe for the packed word
// DONE    | one-cycle done pulse, then back to IDLE
module memory_writer
  import mem_writer_pkg::*;
#(
  parameter int RES_COUNT = 169,
  parameter int ADR_W     = 8,
  parameter int DATA_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADR_W-1:0] base_adr,
  output logic             busy,
  output logic             done,
  memory_writer_if.master  bus
);

  localparam int CNT_W = $clog2(RES_COUNT + 1);
  localparam logic [CNT_W-1:0] RES_TOTAL = CNT_W'(RES_COUNT);
  localparam logic [CNT_W-1:0] RES_LAST  = CNT_W'(RES_COUNT - 1);

  state_e                    state, state_nxt;
  logic [ADR_W-1:0]          base_q;
  logic [ADR_W-1:0]          word_cnt;
  logic [CNT_W-1:0]          res_cnt;
  logic                      start_acc, accept, last_byte, to_write;
  logic [DATA_W-1:0]         word;
  logic                      full;
  logic [BYTES_PER_WORD-1:0] fill_mask;

  assign start_acc = (state == IDLE) && start;
  assign accept    = (state == COLLECT) && bus.res_valid;
  assign last_byte = accept && (res_cnt == RES_LAST);

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_acc || (state == WRITE)),
    .load      (accept),
    .data      (bus.res_data),
    .word      (word),
    .full      (full),
    .fill_mask (fill_mask)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    to_write  = 1'b0;
    unique case (state)
      IDLE:    if (start) state_nxt = COLLECT;
      COLLECT: if (accept && (full || last_byte)) begin
                 state_nxt = WRITE;
                 to_write  = 1'b1;
               end
      WRITE:   state_nxt = (res_cnt == RES_TOTAL) ? DONE : COLLECT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address and data are captured with the last byte so they are stable for the whole WRITE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q          <= '0;
      word_cnt        <= '0;
      res_cnt         <= '0;
      bus.mem_wr_adr  <= '0;
      bus.mem_wr_data <= '0;
    end else begin
      if (start_acc) begin
        base_q   <= base_adr;
        word_cnt <= '0;
        res_cnt  <= '0;
      end
      if (accept) res_cnt <= res_cnt + 1'b1;
      if (to_write) begin
        bus.mem_wr_adr  <= base_q + word_cnt;
        bus.mem_wr_data <= word & lane_bits(fill_mask);
      end
      if (state == WRITE) word_cnt <= word_cnt + 1'b1;
    end
  end

  assign bus.res_ready = (state == COLLECT);
  assign bus.mem_wr_en = (state == WRITE);
  assign busy          = (state == COLLECT) || (state == WRITE);
  assign done          = (state == DONE);

`ifdef MEM_WR_BYTE_MASK_EN
  logic [BYTES_PER_WORD-1:0] byte_en_q;

  always_ff @(posedge clk) begin
    if (rst)           byte_en_q <= '0;
    else if (to_write) byte_en_q <= fill_mask;
  end

  assign bus.mem_byte_en = bus.mem_wr_en ? byte_en_q : '0;
`endif

endmodule

// File: tb/tb_memory_writer.sv
// Scoreboard bench for memory_writer: one instance with RES_COUNT=8, one with RES_COUNT=169.
// Mask checks are compiled in when MEM_WR_BYTE_MASK_EN is defined.
module tb_memory_writer;
  import mem_writer_pkg::*;

  typedef struct packed {
    logic [7:0]  adr;
    logic [31:0] data;
    logic [3:0]  mask;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  logic       a_rst, a_start, a_busy, a_done;
  logic [7:0] a_base;
  logic       b_rst, b_start, b_busy, b_done;
  logic [7:0] b_base;

  memory_writer_if #(.ADR_W(8), .DATA_W(32)) a_if ();
  memory_writer_if #(.ADR_W(8), .DATA_W(32)) b_if ();

  memory_writer #(.RES_COUNT(8), .ADR_W(8), .DATA_W(32)) dut_a (
    .clk(clk), .rst(a_rst), .start(a_start), .base_adr(a_base),
    .busy(a_busy), .done(a_done), .bus(a_if.master)
  );

  memory_writer #(.RES_COUNT(169), .ADR_W(8), .DATA_W(32)) dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .base_adr(b_base),
    .busy(b_busy), .done(b_done), .bus(b_if.master)
  );

  exp_t a_q[$];
  exp_t b_q[$];
  exp_t a_e, b_e;
  int a_done_exp = 0, a_done_seen = 0, a_last_wr = -10;
  int b_done_exp = 0, b_done_seen = 0, b_last_wr = -10;

  always @(negedge clk) begin
    if (a_if.mem_wr_en) begin
      a_last_wr = cyc;
      check("a_ready_in_write", a_if.res_ready, 1'b0);
      if (a_q.size() == 0) begin
        timeout("a_unexpected_write");
      end else begin
        a_e = a_q.pop_front();
        check("a_wr_adr", a_if.mem_wr_adr, a_e.adr);
        check("a_wr_data", a_if.mem_wr_data, a_e.data);
`ifdef MEM_WR_BYTE_MASK_EN
        check("a_byte_en", a_if.mem_byte_en, a_e.mask);
`endif
      end
    end
`ifdef MEM_WR_BYTE_MASK_EN
    else if (a_if.mem_byte_en != 4'b0000) check("a_byte_en_idle", a_if.mem_byte_en, 4'b0000);
`endif
    if (a_done) begin
      a_done_seen++;
      check("a_done_latency", cyc, a_last_wr + 1);
    end
  end

  always @(negedge clk) begin
    if (b_if.mem_wr_en) begin
      b_last_wr = cyc;
      check("b_ready_in_write", b_if.res_ready, 1'b0);
      if (b_q.size() == 0) begin
        timeout("b_unexpected_write");
      end else begin
        b_e = b_q.pop_front();
        check("b_wr_adr", b_if.mem_wr_adr, b_e.adr);
        check("b_wr_data", b_if.mem_wr_data, b_e.data);
`ifdef MEM_WR_BYTE_MASK_EN
        check("b_byte_en", b_if.mem_byte_en, b_e.mask);
`endif
      end
    end
    if (b_done) begin
      b_done_seen++;
      check("b_done_latency", cyc, b_last_wr + 1);
    end
  end

  task automatic a_start_job(input logic [7:0] base);
    a_start = 1'b1;
    a_base  = base;
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic a_feed(input logic [7:0] first, input int n, input bit gappy);
    for (int i = 0; i < n; i++) begin
      int w;
      w = 0;
      a_if.res_valid = 1'b1;
      a_if.res_data  = first + 8'(i);
      while (!a_if.res_ready && w < 50) begin
        @(posedge clk); #1;
        w++;
      end
      if (w >= 50) begin
        timeout("a_feed_ready");
        a_if.res_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      a_if.res_valid = 1'b0;
      if (gappy) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic a_wait_idle();
    int w;
    w = 0;
    while ((a_busy || a_done) && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 100) timeout("a_wait_idle");
  endtask

  task automatic run_a();
    // back-to-back bytes
    a_q.push_back({8'h20, 32'h04030201, 4'hF});
    a_q.push_back({8'h21, 32'h08070605, 4'hF});
    a_done_exp++;
    a_start_job(8'h20);
    a_feed(8'h01, 8, 1'b0);
    a_wait_idle();

    // valid every other cycle
    a_q.push_back({8'h40, 32'h14131211, 4'hF});
    a_q.push_back({8'h41, 32'h18171615, 4'hF});
    a_done_exp++;
    a_start_job(8'h40);
    a_feed(8'h11, 8, 1'b1);
    a_wait_idle();

    // address wrap
    a_q.push_back({8'hFF, 32'hA3A2A1A0, 4'hF});
    a_q.push_back({8'h00, 32'hA7A6A5A4, 4'hF});
    a_done_exp++;
    a_start_job(8'hFF);
    a_feed(8'hA0, 8, 1'b0);
    a_wait_idle();

    // start and base_adr change while busy are ignored
    a_q.push_back({8'h30, 32'hC3C2C1C0, 4'hF});
    a_q.push_back({8'h31, 32'hC7C6C5C4, 4'hF});
    a_done_exp++;
    a_start_job(8'h30);
    a_feed(8'hC0, 2, 1'b0);
    a_start = 1'b1;
    a_base  = 8'h90;
    @(posedge clk); #1;
    a_start = 1'b0;
    check("a_busy_after_restart", a_busy, 1'b1);
    a_feed(8'hC2, 6, 1'b0);
    a_wait_idle();

    // reset after 6 of 8 bytes: only the first word is written
    a_q.push_back({8'h50, 32'hD3D2D1D0, 4'hF});
    a_start_job(8'h50);
    a_feed(8'hD0, 6, 1'b0);
    a_rst = 1'b1;
    @(posedge clk); #1;
    a_rst = 1'b0;
    check("a_rst_busy", a_busy, 1'b0);
    check("a_rst_ready", a_if.res_ready, 1'b0);
    check("a_rst_wr_en", a_if.mem_wr_en, 1'b0);
    check("a_rst_wr_data", a_if.mem_wr_data, 32'h0);
    repeat (10) begin
      @(posedge clk); #1;
    end

    // clean job after the aborted one
    a_q.push_back({8'h60, 32'hE3E2E1E0, 4'hF});
    a_q.push_back({8'h61, 32'hE7E6E5E4, 4'hF});
    a_done_exp++;
    a_start_job(8'h60);
    a_feed(8'hE0, 8, 1'b0);
    a_wait_idle();
  endtask

  task automatic run_b();
    int w;
    for (int k = 0; k < 42; k++) begin
      logic [7:0] b0, b1, b2, b3;
      b0 = 8'(4*k);
      b1 = 8'(4*k + 1);
      b2 = 8'(4*k + 2);
      b3 = 8'(4*k + 3);
      b_q.push_back({8'(8'hF0 + k), b3, b2, b1, b0, 4'hF});
    end
    b_q.push_back({8'h1A, 32'h000000A8, 4'b0001});
    b_done_exp++;

    b_start = 1'b1;
    b_base  = 8'hF0;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int i = 0; i < 169; i++) begin
      w = 0;
      b_if.res_valid = 1'b1;
      b_if.res_data  = 8'(i);
      while (!b_if.res_ready && w < 50) begin
        @(posedge clk); #1;
        w++;
      end
      if (w >= 50) begin
        timeout("b_feed_ready");
        break;
      end
      @(posedge clk); #1;
    end
    b_if.res_valid = 1'b0;
    w = 0;
    while ((b_busy || b_done) && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 100) timeout("b_wait_idle");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst = 1'b1;  a_start = 1'b0;  a_base = 8'h00;
    b_rst = 1'b1;  b_start = 1'b0;  b_base = 8'h00;
    a_if.res_valid = 1'b0;  a_if.res_data = 8'h00;
    b_if.res_valid = 1'b0;  b_if.res_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", a_busy, 1'b0);
    check("reset_done", a_done, 1'b0);
    check("reset_ready", a_if.res_ready, 1'b0);
    check("reset_wr_en", a_if.mem_wr_en, 1'b0);
    check("reset_wr_adr", a_if.mem_wr_adr, 8'h00);
    check("reset_wr_data", a_if.mem_wr_data, 32'h0);
    a_rst = 1'b0;
    b_rst = 1'b0;
    @(posedge clk); #1;

    fork
      run_a();
      run_b();
    join

    repeat (5) @(posedge clk);
    #1;
    check("a_done_count", a_done_seen, a_done_exp);
    check("b_done_count", b_done_seen, b_done_exp);
    check("a_writes_pending", a_q.size(), 0);
    check("b_writes_pending", b_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
